// File: rtl/qracc_tile_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qracc_tile_sched: layer scheduler; weight-tile loads, credit-based MAC    |
// | issue and output buffering for the bit-serial QR accelerator.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module qracc_tile_sched #(
  parameter int NUM_ROWS    = 128,
  parameter int NUM_COLS    = 32,
  parameter int INPUT_BITS  = 4,
  parameter int OUTPUT_BITS = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              start_i,
  input  logic [7:0]                        cfg_num_tiles_i,
  input  logic [15:0]                       cfg_num_vectors_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  input  logic [NUM_COLS-1:0]               w_data_i,
  output logic                              rq_valid_o,
  input  logic                              rq_ready_i,
  output logic                              rq_wr_o,
  output logic [$clog2(NUM_ROWS)-1:0]       addr_o,
  output logic [NUM_COLS-1:0]               wr_data_o,
  input  logic                              x_valid_i,
  output logic                              x_ready_o,
  input  logic [NUM_ROWS*INPUT_BITS-1:0]    x_data_i,
  output logic                              mac_valid_o,
  input  logic                              mac_ready_i,
  output logic [NUM_ROWS*INPUT_BITS-1:0]    mac_data_o,
  input  logic                              acc_valid_i,
  input  logic [NUM_COLS*OUTPUT_BITS-1:0]   acc_data_i,
  output logic                              y_valid_o,
  input  logic                              y_ready_i,
  output logic [NUM_COLS*OUTPUT_BITS-1:0]   y_data_o,
  output logic                              y_last_o
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int Y_W   = NUM_COLS * OUTPUT_BITS;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] CREDITS  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       cfg_tiles;
  logic [15:0]      cfg_vecs;
  logic [7:0]       tile_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [15:0]      vec_cnt;
  logic [CNT_W-1:0] outstanding;
  logic             err;

  logic             tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tag_wr, tag_rd;
  logic [CNT_W-1:0] tag_cnt;

  logic [Y_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] f_wr, f_rd;
  logic [CNT_W-1:0] f_cnt;

  logic in_load, in_comp, issue_ok, issue, w_beat;
  logic last_row, last_vec, last_tile, start_acc;
  logic acc_take, acc_err, y_pop, drain_empty;

  assign in_load     = (state == S_LOAD_W);
  assign in_comp     = (state == S_COMPUTE);
  // Outstanding counts MACs in flight plus FIFO entries, so a credit is a FIFO slot.
  assign issue_ok    = (outstanding < CREDITS);
  assign last_row    = (row_cnt == ROW_LAST);
  assign last_vec    = (vec_cnt == cfg_vecs - 16'd1);
  assign last_tile   = (tile_cnt == cfg_tiles - 8'd1);
  assign start_acc   = (state == S_IDLE) && start_i;
  assign drain_empty = (outstanding == '0);

  assign rq_valid_o  = in_load & w_valid_i;
  assign w_ready_o   = in_load & rq_ready_i;
  assign rq_wr_o     = rq_valid_o;
  assign addr_o      = row_cnt;
  assign wr_data_o   = w_data_i;
  assign w_beat      = rq_valid_o & rq_ready_i;

  assign mac_valid_o = in_comp & x_valid_i & issue_ok;
  assign x_ready_o   = in_comp & mac_ready_i & issue_ok;
  assign mac_data_o  = x_data_i;
  assign issue       = mac_valid_o & mac_ready_i;

  assign acc_take    = acc_valid_i & (tag_cnt != '0);
  assign acc_err     = acc_valid_i & (tag_cnt == '0);

  assign y_valid_o   = (f_cnt != '0);
  assign y_pop       = y_valid_o & y_ready_i;
  // Masked so the uninitialised FIFO storage never shows on the outputs.
  assign y_data_o    = y_valid_o ? fifo_mem[f_rd][Y_W-1:0] : '0;
  assign y_last_o    = y_valid_o & fifo_mem[f_rd][Y_W];

  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign err_o       = err;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if ((cfg_num_tiles_i == 8'd0) || (cfg_num_vectors_i == 16'd0))
            state_nxt = S_DONE;
          else
            state_nxt = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_beat && last_row) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (issue && last_vec) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_empty) state_nxt = last_tile ? S_DONE : S_LOAD_W;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= S_IDLE;
      cfg_tiles   <= '0;
      cfg_vecs    <= '0;
      tile_cnt    <= '0;
      row_cnt     <= '0;
      vec_cnt     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_acc) begin
        cfg_tiles <= cfg_num_tiles_i;
        cfg_vecs  <= cfg_num_vectors_i;
        err       <= 1'b0;
      end else if (acc_err) begin
        err <= 1'b1;
      end

      if (start_acc)
        row_cnt <= '0;
      else if (w_beat)
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;

      // Vector count restarts per tile so last_vec marks every tile's final vector.
      if (start_acc)
        vec_cnt <= '0;
      else if (issue)
        vec_cnt <= last_vec ? 16'd0 : vec_cnt + 16'd1;

      if (start_acc)
        tile_cnt <= '0;
      else if ((state == S_DRAIN) && drain_empty && !last_tile)
        tile_cnt <= tile_cnt + 8'd1;

      case ({issue, y_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue)    tag_wr <= tag_wr + 1'b1;
      if (acc_take) tag_rd <= tag_rd + 1'b1;
      case ({issue, acc_take})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      f_wr  <= '0;
      f_rd  <= '0;
      f_cnt <= '0;
    end else begin
      if (acc_take) f_wr <= f_wr + 1'b1;
      if (y_pop)    f_rd <= f_rd + 1'b1;
      case ({acc_take, y_pop})
        2'b10:   f_cnt <= f_cnt + 1'b1;
        2'b01:   f_cnt <= f_cnt - 1'b1;
        default: f_cnt <= f_cnt;
      endcase
    end
  end

  // Storage needs no reset: the pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (issue)    tag_mem[tag_wr] <= last_vec;
    if (acc_take) fifo_mem[f_wr]  <= {tag_mem[tag_rd], acc_data_i};
  end

endmodule
`default_nettype wire

// File: tb/tb_qracc_tile_sched.sv
`default_nettype none
// Bench for qracc_tile_sched: directed layers with a stand-in accelerator and
// a queue-based scoreboard on the output stream.
`timescale 1ns/1ps
module tb_qracc_tile_sched;

  localparam int LAT = 5;

  logic         clk, nrst, start_i;
  logic [7:0]   cfg_num_tiles_i;
  logic [15:0]  cfg_num_vectors_i;
  logic         busy_o, done_o, err_o;
  logic         w_valid_i, w_ready_o;
  logic [31:0]  w_data_i;
  logic         rq_valid_o, rq_ready_i, rq_wr_o;
  logic [6:0]   addr_o;
  logic [31:0]  wr_data_o;
  logic         x_valid_i, x_ready_o;
  logic [511:0] x_data_i;
  logic         mac_valid_o, mac_ready_i;
  logic [511:0] mac_data_o;
  logic         acc_valid_i;
  logic [127:0] acc_data_i;
  logic         y_valid_o, y_ready_i, y_last_o;
  logic [127:0] y_data_o;

  qracc_tile_sched dut (
    .clk(clk), .nrst(nrst), .start_i(start_i),
    .cfg_num_tiles_i(cfg_num_tiles_i), .cfg_num_vectors_i(cfg_num_vectors_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .rq_valid_o(rq_valid_o), .rq_ready_i(rq_ready_i), .rq_wr_o(rq_wr_o),
    .addr_o(addr_o), .wr_data_o(wr_data_o),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
    .mac_valid_o(mac_valid_o), .mac_ready_i(mac_ready_i), .mac_data_o(mac_data_o),
    .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_data_o(y_data_o),
    .y_last_o(y_last_o)
  );

  typedef struct {
    logic         last;
    logic [127:0] d;
  } item_t;
  typedef struct {
    logic [127:0] d;
    int           due;
  } pend_t;

  item_t xq[$];
  item_t exp_q[$];
  pend_t pend[$];

  logic [127:0] vtab [8];
  int checks = 0, failures = 0;
  int cyc = 0, spur_cyc = -1;
  int wr_cnt = 0, mac_cnt = 0, y_cnt = 0, done_cnt = 0, exp_addr = 0;
  int b_wr, b_mac, b_y, b_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [519:0] act, input logic [519:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  initial begin
    vtab[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vtab[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    vtab[2] = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FACE_B00C;
    vtab[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    vtab[4] = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
    vtab[5] = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
    vtab[6] = 128'h0000_0000_0000_0000_0000_0000_0000_0000;
    vtab[7] = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_7E7E_8181;
  end

  // Weight stream: always valid, random data, SRAM port stalls every 5th cycle.
  initial begin
    w_valid_i = 1'b1; w_data_i = '0; rq_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      w_data_i   = $urandom;
      rq_ready_i = ((cyc % 5) != 3);
    end
  end

  always @(negedge clk) begin
    if (rq_valid_o && rq_ready_i) begin
      chk("rq_beat", {rq_wr_o, addr_o, wr_data_o}, {1'b1, 7'(exp_addr), w_data_i});
      exp_addr = (exp_addr + 1) % 128;
      wr_cnt++;
    end
    if (done_o) done_cnt++;
  end

  // Input feeder: the expected output is queued at the moment a vector issues.
  initial begin
    item_t it;
    x_valid_i = 1'b0; x_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (xq.size() > 0) begin
        x_valid_i = 1'b1;
        x_data_i  = {4{xq[0].d}};
      end else begin
        x_valid_i = 1'b0;
      end
      @(negedge clk);
      if (x_valid_i && x_ready_o) begin
        chk("mac_issue", {mac_valid_o, mac_data_o}, {1'b1, x_data_i});
        it = xq.pop_front();
        exp_q.push_back(it);
        mac_cnt++;
      end
    end
  end

  // Stand-in accelerator: echoes the low 128 bits of each MAC after LAT cycles.
  always @(negedge clk) begin
    pend_t p;
    if (mac_valid_o && mac_ready_i) begin
      p.d   = mac_data_o[127:0];
      p.due = cyc + LAT;
      pend.push_back(p);
    end
  end

  initial begin
    acc_valid_i = 1'b0; acc_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (cyc == spur_cyc) begin
        acc_valid_i = 1'b1;
        acc_data_i  = 128'h5A5A_0000_0000_0000_0000_0000_0000_A5A5;
      end else if (pend.size() > 0 && cyc >= pend[0].due) begin
        acc_valid_i = 1'b1;
        acc_data_i  = pend[0].d;
        pend.pop_front();
      end else begin
        acc_valid_i = 1'b0;
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    item_t it;
    if (y_valid_o && y_ready_i) begin
      y_cnt++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL y_unexpected actual=%0h required=none", y_data_o);
      end else begin
        it = exp_q.pop_front();
        chk("y_beat", {y_last_o, y_data_o}, {it.last, it.d});
      end
    end
  end

  task automatic start_layer(input int tiles, input int vecs);
    item_t it;
    for (int t = 0; t < tiles; t++)
      for (int v = 0; v < vecs; v++) begin
        it.last = (v == vecs - 1);
        it.d    = vtab[(t * vecs + v) % 8];
        xq.push_back(it);
      end
    b_wr = wr_cnt; b_mac = mac_cnt; b_y = y_cnt; b_done = done_cnt;
    @(posedge clk); #1;
    cfg_num_tiles_i = 8'(tiles); cfg_num_vectors_i = 16'(vecs); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("start_load", {busy_o, err_o, rq_valid_o, addr_o}, {1'b1, 1'b0, 1'b1, 7'd0});
  endtask

  task automatic finish_layer(input int tiles, input int vecs);
    bit seen = 0;
    int n = 0;
    while (!seen && n < 4000) begin
      @(negedge clk);
      if (done_o) seen = 1;
      n++;
    end
    chk("done_seen", seen, 1);
    chk("busy_at_done", busy_o, 1);
    @(negedge clk);
    chk("idle_after_done", {busy_o, done_o}, 0);
    chk("wr_count", wr_cnt - b_wr, 128 * tiles);
    chk("mac_count", mac_cnt - b_mac, tiles * vecs);
    chk("y_count", y_cnt - b_y, tiles * vecs);
    chk("done_count", done_cnt - b_done, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit found, d1, d2;
    int n;
    nrst = 1'b0; start_i = 1'b0; cfg_num_tiles_i = '0; cfg_num_vectors_i = '0;
    mac_ready_i = 1'b1; y_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {busy_o, done_o, err_o, w_ready_o, rq_valid_o, rq_wr_o, addr_o,
         x_ready_o, mac_valid_o, y_valid_o, y_last_o}, 0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // Basic layer.
    start_layer(1, 3);
    finish_layer(1, 3);

    // Backpressure: credits stop issue after FIFO_DEPTH MACs.
    y_ready_i = 1'b0;
    start_layer(1, 8);
    repeat (400) @(negedge clk);
    chk("bp_mac_count", mac_cnt - b_mac, 4);
    chk("bp_x_ready", {x_ready_o, mac_valid_o}, 0);
    chk("bp_y_valid", y_valid_o, 1);
    @(posedge clk); #1;
    y_ready_i = 1'b1;
    finish_layer(1, 8);

    // Multi-tile.
    start_layer(3, 2);
    finish_layer(3, 2);

    // Spurious accelerator result while idle.
    @(posedge clk); #1;
    spur_cyc = cyc + 2;
    repeat (4) @(negedge clk);
    chk("spur_err", {err_o, y_valid_o}, 2'b10);
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", {err_o, y_valid_o, busy_o}, 3'b100);

    // Zero config: start clears err, no traffic, done shortly after.
    b_wr = wr_cnt; b_mac = mac_cnt; b_done = done_cnt;
    @(posedge clk); #1;
    cfg_num_tiles_i = 8'd2; cfg_num_vectors_i = 16'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    d1 = done_o;
    chk("zero_err_cleared", err_o, 0);
    @(negedge clk);
    d2 = done_o;
    chk("zero_done", d1 | d2, 1);
    repeat (4) @(negedge clk);
    chk("zero_no_traffic", {wr_cnt - b_wr, mac_cnt - b_mac}, 0);
    chk("zero_done_once", done_cnt - b_done, 1);
    chk("zero_idle", busy_o, 0);

    // Reset with two MACs in flight.
    start_layer(1, 4);
    found = 0; n = 0;
    while (!found && n < 1000) begin
      @(negedge clk);
      if (mac_cnt - b_mac >= 2) found = 1;
      n++;
    end
    chk("rst_two_issued", {found, 32'(mac_cnt - b_mac)}, {1'b1, 32'd2});
    @(posedge clk); #1;
    nrst = 1'b0; mac_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_outputs",
        {busy_o, done_o, err_o, w_ready_o, rq_valid_o, rq_wr_o, addr_o,
         x_ready_o, mac_valid_o, y_valid_o, y_last_o}, 0);
    xq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    nrst = 1'b1; mac_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_late_result_err", {err_o, y_valid_o, busy_o}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
